trap_ctrl: RTL and testbench
============================

# trap_ctrl

Sequencer for machine-mode trap entry and return in the core. It detects exceptions, interrupts and MRET on the instruction in execute, and stalls and flushes the pipeline. It waits for outstanding memory traffic to drain, then drives the CSR unit's trap handshake (`trap_enter`, `trap_pc`, `trap_cause`, `mret_exec`) and issues a single-cycle PC redirect to the handler or to `mepc`.

## Interface
- `DRAIN_MAX`, 15: maximum DRAIN cycles before entry is forced; range 1..255.
- `clk` in 1: core clock.
- `rst` in 1: asynchronous, active-low reset.
- `ex_valid` in 1: execute-stage instruction valid.
- `ex_pc` in 32: PC of execute-stage instruction.
- `ecall_i`, `ebreak_i`, `illegal_i`, `mret_i` in 1 each: decode flags, qualified by `ex_valid`.
- `pipe_busy` in 1: load/store outstanding.
- `interrupt_pending` in 1: from CSR unit.
- `interrupt_cause` in 32: from CSR unit.
- `mtvec` in 32: from CSR unit.
- `mepc` in 32: from CSR unit.
- `stall_o` out 1: freeze fetch/decode/execute.
- `flush_o` out 1: kill execute-stage and younger instructions.
- `trap_enter` out 1: one-cycle pulse to CSR unit.
- `trap_pc` out 32: saved PC.
- `trap_cause` out 32: mcause value.
- `mret_exec` out 1: one-cycle pulse to CSR unit.
- `redirect_valid` out 1: one-cycle pulse to PC unit.
- `redirect_pc` out 32: new PC, 4-byte aligned.

## Operation
- States: RUN, DRAIN, ENTER, REDIRECT, RETURN. Reset state is RUN.
- Event detection happens in RUN with `ex_valid`=1. Priority, highest first:
  - interrupt (`interrupt_pending`=1): cause = `interrupt_cause`.
  - `illegal_i`: cause 2.
  - `ebreak_i`: cause 3.
  - `ecall_i`: cause 11.
  - `mret_i`.
- Trap event in RUN:
  - Latch cause into `cause_q` and `ex_pc` into `pc_q`.
  - Clear the drain counter.
  - Go to DRAIN.
- DRAIN:
  - Counter increments each cycle.
  - Exit to ENTER when `pipe_busy`=0, or when the counter reaches `DRAIN_MAX`.
- ENTER:
  - `trap_enter`=1, `trap_pc`=`pc_q`, `trap_cause`=`cause_q`.
  - Go to REDIRECT.
- REDIRECT:
  - `redirect_valid`=1, `redirect_pc`={`mtvec`[31:2],2'b00}.
  - Vectored targets per Configuration.
  - Go to RUN.
- `mret_i` with no higher-priority event: go to RETURN.
- RETURN:
  - `mret_exec`=1, `redirect_valid`=1, `redirect_pc`={`mepc`[31:2],2'b00}.
  - Go to RUN.
- `stall_o`=1 when state≠RUN, or in RUN when any event is detected (combinational).
- `flush_o`=1 in RUN on a detected event, and in REDIRECT and RETURN.
- Inputs are ignored outside RUN; events are never queued.
- Cause overrides:
  - An interrupt that becomes pending during DRAIN is not re-sampled. The CSR unit substitutes its live interrupt cause at `trap_enter`. The excepting instruction then re-executes and re-raises after the handler.
  - An interrupt that deasserts during DRAIN does not cancel entry; `cause_q` is still presented.
- Asynchronous reset in any state:
  - Return to RUN.
  - All outputs, `cause_q`, `pc_q` and the counter go to 0.
- Unused outputs are held at 0 in every state.

## Timing
- Trap with `pipe_busy`=0 at detection, detection at cycle 0:
  - cycle 1 DRAIN.
  - cycle 2 `trap_enter`.
  - cycle 3 `redirect_valid`.
  - cycle 4 RUN.
- Each extra `pipe_busy` cycle adds one cycle.
- Worst-case entry: `trap_enter` at cycle `DRAIN_MAX`+1.
- MRET detected at cycle 0: `mret_exec` and `redirect_valid` both at cycle 1; RUN at cycle 2.
- Minimum spacing between consecutive trap entries is 4 cycles.
- `redirect_pc` uses the CSR values sampled in the redirect cycle. `mepc` already holds `pc_q` in REDIRECT, because the CSR unit writes it at the ENTER edge.

## Configuration
- `TRAP_VECTORED_EN` defined:
  - In REDIRECT, if `mtvec`[1:0]=2'b01 and `cause_q`[31]=1, `redirect_pc`={`mtvec`[31:2],2'b00}+(`cause_q`[4:0]<<2).
  - Exceptions always go to the base.
- `TRAP_VECTORED_EN` undefined: always the base; `mtvec`[1:0] is ignored.

## Structure
- Shared core package holds:
  - State encodings: RUN=0, DRAIN=1, ENTER=2, REDIRECT=3, RETURN=4, 3-bit.
  - Exception cause constants: `CAUSE_ILLEGAL`=2, `CAUSE_BREAKPOINT`=3, `CAUSE_ECALL_M`=11.
- Single module; no sub-module. The drain counter is 8 bits, inline.

## Test plan
- ECALL at `ex_pc`=0x0000_0040, `pipe_busy`=0, `mtvec`=0x100 -> `trap_enter` at cycle 2 with `trap_pc`=0x40, `trap_cause`=11; `redirect_pc`=0x100 at cycle 3.
- Illegal instruction with `pipe_busy` high for 5 cycles -> `trap_enter` 5 cycles later than the no-busy case; `pipe_busy` stuck high -> entry forced at cycle 16 (`DRAIN_MAX`=15).
- `interrupt_pending` with cause 0x8000_0007 coinciding with ECALL -> `trap_cause`=0x8000_0007. With `TRAP_VECTORED_EN` and `mtvec`=0x101, `redirect_pc`=0x11C; without the macro, 0x100.
- MRET with `mepc`=0x0000_0208 -> `mret_exec` and `redirect_valid` at cycle 1, `redirect_pc`=0x208; an MRET with `illegal_i` also set takes the cause-2 trap instead.
- `rst` low during DRAIN -> all outputs 0 immediately; after release, no `trap_enter` is issued.

Source files
------------

// File: rtl/trap_ctrl_pkg.sv
// Shared definitions for the machine-mode trap sequencer: FSM state encoding,
// synchronous exception cause codes, the decoded-event record and small
// helpers used by trap_ctrl.
package trap_ctrl_pkg;

  // Sequencer states; the encoding is shared with the rest of the core.
  typedef enum logic [2:0] {
    ST_RUN      = 3'd0,
    ST_DRAIN    = 3'd1,
    ST_ENTER    = 3'd2,
    ST_REDIRECT = 3'd3,
    ST_RETURN   = 3'd4
  } state_t;

  // mcause values for the synchronous exceptions raised from execute.
  localparam logic [31:0] CAUSE_ILLEGAL    = 32'd2;
  localparam logic [31:0] CAUSE_BREAKPOINT = 32'd3;
  localparam logic [31:0] CAUSE_ECALL_M    = 32'd11;

  // Width of the inline drain watchdog counter.
  localparam int DRAIN_CNT_W = 8;

  // Result of looking at the execute-stage instruction in one cycle.
  // trap and mret are mutually exclusive; cause is meaningful only with trap.
  typedef struct packed {
    logic        trap;
    logic        mret;
    logic [31:0] cause;
  } event_t;

  // Prioritised event decode: interrupt, illegal, ebreak, ecall, then mret.
  function automatic event_t detect_event(
    input logic        valid,
    input logic        irq,
    input logic [31:0] irq_cause,
    input logic        illegal,
    input logic        ebreak,
    input logic        ecall,
    input logic        mret
  );
    event_t e;
    e = '0;
    if (valid) begin
      if (irq) begin
        e.trap  = 1'b1;
        e.cause = irq_cause;
      end else if (illegal) begin
        e.trap  = 1'b1;
        e.cause = CAUSE_ILLEGAL;
      end else if (ebreak) begin
        e.trap  = 1'b1;
        e.cause = CAUSE_BREAKPOINT;
      end else if (ecall) begin
        e.trap  = 1'b1;
        e.cause = CAUSE_ECALL_M;
      end else if (mret) begin
        e.mret  = 1'b1;
      end
    end
    return e;
  endfunction

  // Force a code address onto a 4-byte boundary.
  function automatic logic [31:0] align4(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/trap_ctrl.sv
// Machine-mode trap entry / MRET sequencer.
// Watches the execute-stage instruction, stalls and flushes the pipe on a
// trap or MRET, waits (bounded by DRAIN_MAX) for memory traffic to drain,
// pulses the CSR handshake and issues a one-cycle PC redirect.
// Optional feature: define TRAP_VECTORED_EN to send interrupts to
// mtvec base + 4*cause when mtvec is in vectored mode (mtvec[1:0]=2'b01).
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter int DRAIN_MAX = 15  // 1..255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [31:0] ex_pc,
  input  logic        ecall_i,
  input  logic        ebreak_i,
  input  logic        illegal_i,
  input  logic        mret_i,
  input  logic        pipe_busy,
  input  logic        interrupt_pending,
  input  logic [31:0] interrupt_cause,
  input  logic [31:0] mtvec,
  input  logic [31:0] mepc,
  output logic        stall_o,
  output logic        flush_o,
  output logic        trap_enter,
  output logic [31:0] trap_pc,
  output logic [31:0] trap_cause,
  output logic        mret_exec,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);

  // Drain ends on the DRAIN cycle whose incremented count reaches DRAIN_MAX,
  // which puts forced entry at cycle DRAIN_MAX+1 after detection.
  localparam logic [DRAIN_CNT_W-1:0] DRAIN_LAST = DRAIN_CNT_W'(DRAIN_MAX - 1);

  state_t                 state;
  state_t                 next_state;
  event_t                 evt;
  logic                   run_trap;
  logic                   run_mret;
  logic                   drain_done;
  logic [31:0]            cause_q;
  logic [31:0]            pc_q;
  logic [DRAIN_CNT_W-1:0] drain_cnt;
  logic [31:0]            handler_pc;

  // The low mode/alignment bits of mtvec and mepc never form part of a
  // target address; they are gathered here so their non-use is explicit.
  logic unused_addr_bits;
  assign unused_addr_bits = &{1'b0, mtvec[1:0], mepc[1:0]};

  // Decode the execute-stage instruction; only acted upon while running.
  assign evt        = detect_event(ex_valid, interrupt_pending, interrupt_cause,
                                   illegal_i, ebreak_i, ecall_i, mret_i);
  assign run_trap   = (state == ST_RUN) && evt.trap;
  assign run_mret   = (state == ST_RUN) && evt.mret;
  assign drain_done = (drain_cnt >= DRAIN_LAST);

  // Handler address; interrupts may be vectored when the feature is built in.
  always_comb begin
    handler_pc = align4(mtvec);
`ifdef TRAP_VECTORED_EN
    if ((mtvec[1:0] == 2'b01) && cause_q[31]) begin
      handler_pc = align4(mtvec) + {25'd0, cause_q[4:0], 2'b00};
    end
`endif
  end

  // State register.
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of the order blocks are evaluated.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_RUN;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic.
  // NOTE: every combinational output gets a default before the case so that
  // no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = state;
    unique case (state)
      ST_RUN: begin
        if (run_trap) begin
          next_state = ST_DRAIN;
        end else if (run_mret) begin
          next_state = ST_RETURN;
        end
      end
      ST_DRAIN: begin
        if (!pipe_busy || drain_done) begin
          next_state = ST_ENTER;
        end
      end
      ST_ENTER:    next_state = ST_REDIRECT;
      ST_REDIRECT: next_state = ST_RUN;
      ST_RETURN:   next_state = ST_RUN;
      default:     next_state = ST_RUN;
    endcase
  end

  // Trap context capture and the drain watchdog counter.
  // NOTE: these are plain registers, not a memory, so they take the async
  // reset and read as zero after reset like the rest of the block.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cause_q   <= '0;
      pc_q      <= '0;
      drain_cnt <= '0;
    end else if (run_trap) begin
      cause_q   <= evt.cause;
      pc_q      <= ex_pc;
      drain_cnt <= '0;
    end else if (state == ST_DRAIN) begin
      drain_cnt <= drain_cnt + 1'b1;
    end
  end

  // Output decode; anything not driven in a state stays at zero.
  always_comb begin
    stall_o        = 1'b0;
    flush_o        = 1'b0;
    trap_enter     = 1'b0;
    trap_pc        = '0;
    trap_cause     = '0;
    mret_exec      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    unique case (state)
      ST_RUN: begin
        // Stall/flush react in the detection cycle itself.
        stall_o = run_trap || run_mret;
        flush_o = run_trap || run_mret;
      end
      ST_DRAIN: begin
        stall_o = 1'b1;
      end
      ST_ENTER: begin
        stall_o    = 1'b1;
        trap_enter = 1'b1;
        trap_pc    = pc_q;
        trap_cause = cause_q;
      end
      ST_REDIRECT: begin
        stall_o        = 1'b1;
        flush_o        = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = handler_pc;
      end
      ST_RETURN: begin
        stall_o        = 1'b1;
        flush_o        = 1'b1;
        mret_exec      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = align4(mepc);
      end
      default: begin
        stall_o = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: directed vector table, a reset-in-DRAIN
// sequence and randomized transactions scored against a transaction-level
// model. Honours TRAP_VECTORED_EN the same way the design does.
module tb_trap_ctrl;

  localparam int DMAX = 15;
  localparam int K_NONE = 0;
  localparam int K_TRAP = 1;
  localparam int K_MRET = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic        ecall_i, ebreak_i, illegal_i, mret_i;
  logic        pipe_busy;
  logic        interrupt_pending;
  logic [31:0] interrupt_cause;
  logic [31:0] mtvec;
  logic [31:0] mepc;
  logic        stall_o, flush_o, trap_enter, mret_exec, redirect_valid;
  logic [31:0] trap_pc, trap_cause, redirect_pc;

  typedef struct packed {
    logic        stall;
    logic        flush;
    logic        enter;
    logic [31:0] tpc;
    logic [31:0] tcause;
    logic        mret;
    logic        rv;
    logic [31:0] rpc;
  } outs_t;

  typedef struct {
    bit          v;
    bit          ip;
    logic [31:0] ic;
    bit          il;
    bit          eb;
    bit          ec;
    bit          mr;
    logic [31:0] pc;
    int          busy;
    logic [31:0] tv;
    logic [31:0] ep;
  } stim_t;

  typedef struct {
    int          kind;
    int          t_enter;
    logic [31:0] pc;
    logic [31:0] cause;
    logic [31:0] target;
  } exp_t;

  typedef struct {
    string name;
    stim_t s;
    exp_t  e;
  } vec_t;

  int checks = 0;
  int errors = 0;

  trap_ctrl #(.DRAIN_MAX(DMAX)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ecall_i(ecall_i), .ebreak_i(ebreak_i), .illegal_i(illegal_i), .mret_i(mret_i),
    .pipe_busy(pipe_busy), .interrupt_pending(interrupt_pending),
    .interrupt_cause(interrupt_cause), .mtvec(mtvec), .mepc(mepc),
    .stall_o(stall_o), .flush_o(flush_o), .trap_enter(trap_enter),
    .trap_pc(trap_pc), .trap_cause(trap_cause), .mret_exec(mret_exec),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  function automatic outs_t cur();
    outs_t o;
    o = '{stall: stall_o, flush: flush_o, enter: trap_enter, tpc: trap_pc,
          tcause: trap_cause, mret: mret_exec, rv: redirect_valid, rpc: redirect_pc};
    return o;
  endfunction

  task automatic check(input string name, input outs_t got, input outs_t want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got stall=%0b flush=%0b enter=%0b tpc=%h tcause=%h mret=%0b rv=%0b rpc=%h | want stall=%0b flush=%0b enter=%0b tpc=%h tcause=%h mret=%0b rv=%0b rpc=%h",
               name, got.stall, got.flush, got.enter, got.tpc, got.tcause, got.mret, got.rv, got.rpc,
               want.stall, want.flush, want.enter, want.tpc, want.tcause, want.mret, want.rv, want.rpc);
    end
  endtask

  function automatic stim_t st(bit v, bit ip, logic [31:0] ic, bit il, bit eb, bit ec, bit mr,
                               logic [31:0] pc, int busy, logic [31:0] tv, logic [31:0] ep);
    stim_t s;
    s = '{v: v, ip: ip, ic: ic, il: il, eb: eb, ec: ec, mr: mr, pc: pc, busy: busy, tv: tv, ep: ep};
    return s;
  endfunction

  function automatic exp_t ex(int kind, int t, logic [31:0] pc, logic [31:0] cause, logic [31:0] target);
    exp_t e;
    e = '{kind: kind, t_enter: t, pc: pc, cause: cause, target: target};
    return e;
  endfunction

  // Transaction-level reference: which event wins, how long the drain lasts,
  // and where control ends up.
  function automatic exp_t ref_model(stim_t s);
    exp_t        e;
    int          nd;
    logic [31:0] base;
    e = ex(K_NONE, 0, 32'h0, 32'h0, 32'h0);
    if (!s.v) return e;
    if (s.ip)      begin e.kind = K_TRAP; e.cause = s.ic;   end
    else if (s.il) begin e.kind = K_TRAP; e.cause = 32'd2;  end
    else if (s.eb) begin e.kind = K_TRAP; e.cause = 32'd3;  end
    else if (s.ec) begin e.kind = K_TRAP; e.cause = 32'd11; end
    else if (s.mr) begin
      e.kind    = K_MRET;
      e.t_enter = 1;
      e.target  = s.ep & 32'hFFFF_FFFC;
      return e;
    end else return e;
    nd        = (s.busy + 1 > DMAX) ? DMAX : s.busy + 1;
    e.t_enter = 1 + nd;
    e.pc      = s.pc;
    base      = s.tv & 32'hFFFF_FFFC;
    e.target  = base;
`ifdef TRAP_VECTORED_EN
    if (s.tv[1:0] == 2'b01 && e.cause[31]) e.target = base + 32'(e.cause[4:0]) * 32'd4;
`endif
    return e;
  endfunction

  task automatic drive_idle();
    ex_valid = 0; ecall_i = 0; ebreak_i = 0; illegal_i = 0; mret_i = 0;
    interrupt_pending = 0; interrupt_cause = 32'h0; ex_pc = 32'h0; pipe_busy = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one event at cycle 0, then walk the expected cycle-by-cycle
  // outputs until the sequencer is back in RUN. Execute-side inputs carry
  // random noise while the sequencer is busy; they must be ignored.
  task automatic run_txn(input string name, input stim_t s, input exp_t e);
    int    last;
    outs_t want;
    last = (e.kind == K_TRAP) ? e.t_enter + 2 : (e.kind == K_MRET) ? 2 : 1;
    mtvec = s.tv;
    mepc  = s.ep;
    for (int k = 0; k <= last; k++) begin
      if (k == 0) begin
        ex_valid = s.v; interrupt_pending = s.ip; interrupt_cause = s.ic;
        illegal_i = s.il; ebreak_i = s.eb; ecall_i = s.ec; mret_i = s.mr;
        ex_pc = s.pc; pipe_busy = 0;
      end else if (k < last) begin
        ex_valid = 1'($urandom); interrupt_pending = 1'($urandom); interrupt_cause = $urandom;
        illegal_i = 1'($urandom); ebreak_i = 1'($urandom); ecall_i = 1'($urandom);
        mret_i = 1'($urandom); ex_pc = $urandom; pipe_busy = (k <= s.busy);
      end else begin
        drive_idle();
      end
      want = '0;
      if (e.kind == K_TRAP) begin
        if (k == 0) begin
          want.stall = 1; want.flush = 1;
        end else if (k < e.t_enter) begin
          want.stall = 1;
        end else if (k == e.t_enter) begin
          want.stall = 1; want.enter = 1; want.tpc = e.pc; want.tcause = e.cause;
        end else if (k == e.t_enter + 1) begin
          want.stall = 1; want.flush = 1; want.rv = 1; want.rpc = e.target;
        end
      end else if (e.kind == K_MRET) begin
        if (k == 0) begin
          want.stall = 1; want.flush = 1;
        end else if (k == 1) begin
          want.stall = 1; want.flush = 1; want.mret = 1; want.rv = 1; want.rpc = e.target;
        end
      end
      @(negedge clk);
      check($sformatf("%s c%0d", name, k), cur(), want);
      tick();
    end
  endtask

  vec_t vecs[16];

  initial begin
    logic [31:0] vec_tgt_7, vec_tgt_1f;
`ifdef TRAP_VECTORED_EN
    vec_tgt_7  = 32'h0000_011C;
    vec_tgt_1f = 32'h0000_027C;
`else
    vec_tgt_7  = 32'h0000_0100;
    vec_tgt_1f = 32'h0000_0200;
`endif
    vecs[0]  = '{"ecall",        st(1,0,0,0,0,1,0, 32'h40, 0, 32'h100, 0),      ex(K_TRAP, 2, 32'h40, 11, 32'h100)};
    vecs[1]  = '{"illegal_busy5", st(1,0,0,1,0,0,0, 32'h80, 5, 32'h100, 0),     ex(K_TRAP, 7, 32'h80, 2, 32'h100)};
    vecs[2]  = '{"busy_stuck",   st(1,0,0,1,0,0,0, 32'h84, 40, 32'h100, 0),     ex(K_TRAP, 16, 32'h84, 2, 32'h100)};
    vecs[3]  = '{"irq_ecall",    st(1,1,32'h8000_0007,0,0,1,0, 32'h90, 0, 32'h101, 0), ex(K_TRAP, 2, 32'h90, 32'h8000_0007, vec_tgt_7)};
    vecs[4]  = '{"mret",         st(1,0,0,0,0,0,1, 32'h50, 0, 32'h100, 32'h208), ex(K_MRET, 1, 0, 0, 32'h208)};
    vecs[5]  = '{"mret_illegal", st(1,0,0,1,0,0,1, 32'hA0, 0, 32'h100, 32'h208), ex(K_TRAP, 2, 32'hA0, 2, 32'h100)};
    vecs[6]  = '{"ebreak_ecall", st(1,0,0,0,1,1,0, 32'hB0, 0, 32'h2000, 0),     ex(K_TRAP, 2, 32'hB0, 3, 32'h2000)};
    vecs[7]  = '{"invalid_ecall", st(0,0,0,0,0,1,0, 32'hB4, 0, 32'h100, 0),     ex(K_NONE, 0, 0, 0, 0)};
    vecs[8]  = '{"invalid_irq",  st(0,1,32'h8000_0003,0,0,0,0, 32'hB8, 0, 32'h100, 0), ex(K_NONE, 0, 0, 0, 0)};
    vecs[9]  = '{"mret_unalign", st(1,0,0,0,0,0,1, 32'h60, 0, 32'h100, 32'h20B), ex(K_MRET, 1, 0, 0, 32'h208)};
    vecs[10] = '{"exc_vec_mode", st(1,0,0,1,0,0,0, 32'hC0, 1, 32'h101, 0),      ex(K_TRAP, 3, 32'hC0, 2, 32'h100)};
    vecs[11] = '{"busy13",       st(1,0,0,0,0,1,0, 32'hC4, 13, 32'h100, 0),     ex(K_TRAP, 15, 32'hC4, 11, 32'h100)};
    vecs[12] = '{"busy14",       st(1,0,0,0,0,1,0, 32'hC8, 14, 32'h100, 0),     ex(K_TRAP, 16, 32'hC8, 11, 32'h100)};
    vecs[13] = '{"ebreak_top",   st(1,0,0,0,1,0,0, 32'hFFFF_FFFC, 0, 32'hFFFF_FF03, 0), ex(K_TRAP, 2, 32'hFFFF_FFFC, 3, 32'hFFFF_FF00)};
    vecs[14] = '{"irq_only_1f",  st(1,1,32'h8000_001F,0,0,0,0, 32'hD0, 2, 32'h201, 0), ex(K_TRAP, 4, 32'hD0, 32'h8000_001F, vec_tgt_1f)};
    vecs[15] = '{"irq_mode2",    st(1,1,32'h8000_0003,0,0,0,0, 32'hD4, 0, 32'h102, 0), ex(K_TRAP, 2, 32'hD4, 32'h8000_0003, 32'h100)};

    // Reset state.
    drive_idle();
    mtvec = 32'h100; mepc = 32'h0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_state", cur(), '0);
    rst = 1'b1;
    tick();

    // Directed vectors.
    foreach (vecs[i]) run_txn(vecs[i].name, vecs[i].s, vecs[i].e);

    // Asynchronous reset while draining: outputs clear at once, and no
    // entry follows after release.
    begin
      outs_t want;
      mtvec = 32'h100;
      ex_valid = 1; ecall_i = 1; ex_pc = 32'h70; pipe_busy = 0;
      @(negedge clk);
      want = '0; want.stall = 1; want.flush = 1;
      check("rst_seq detect", cur(), want);
      tick();
      drive_idle();
      pipe_busy = 1;
      @(negedge clk);
      want = '0; want.stall = 1;
      check("rst_seq drain", cur(), want);
      #2 rst = 1'b0;
      #1 check("rst_seq async", cur(), '0);
      @(negedge clk);
      check("rst_seq held", cur(), '0);
      #1 rst = 1'b1;
      pipe_busy = 0;
      for (int k = 0; k < 20; k++) begin
        tick();
        @(negedge clk);
        check($sformatf("rst_seq post c%0d", k), cur(), '0);
      end
      tick();
    end

    // Randomized transactions against the reference model.
    for (int n = 0; n < 200; n++) begin
      stim_t s;
      s.v  = ($urandom % 8) != 0;
      s.ip = ($urandom % 6) == 0;
      s.ic = {1'($urandom), 26'($urandom), 5'($urandom)};
      s.il = ($urandom % 4) == 0;
      s.eb = ($urandom % 4) == 0;
      s.ec = ($urandom % 4) == 0;
      s.mr = ($urandom % 3) == 0;
      s.pc = $urandom;
      s.busy = $urandom_range(0, 20);
      s.tv = {$urandom} & 32'hFFFF_FFFC | 32'($urandom_range(0, 1));
      s.ep = $urandom;
      run_txn($sformatf("rand%0d", n), s, ref_model(s));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
